// File: rtl/pm_host_pkg.sv
// rtl/pm_host_pkg.sv - shared sizes, state encoding and operand indices for the point-multiplication host bridge
// Ports: none (package).
package pm_host_pkg;

    localparam int N     = 233;
    localparam int W     = 32;
    localparam int WORDS = (N + W - 1) / W;
    localparam int OPS   = 4;
    localparam int WCW   = $clog2(WORDS);
    localparam int WC_W  = $clog2(OPS * WORDS);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FIRE = 3'd2,
        ST_WAIT = 3'd3,
        ST_SEND = 3'd4
    } state_t;

    localparam logic [1:0] OP_PX  = 2'd0;
    localparam logic [1:0] OP_PY  = 2'd1;
    localparam logic [1:0] OP_Z   = 2'd2;
    localparam logic [1:0] OP_KEY = 2'd3;

endpackage

// File: rtl/pm_word_unpack.sv
// rtl/pm_word_unpack.sv - selects W-bit word idx of an N-bit value, zero-extended above bit N-1
// Ports: value (N-bit source), idx (word index), word (selected W-bit word).
module pm_word_unpack
    import pm_host_pkg::*;
(
    input  logic [N-1:0]   value,
    input  logic [WCW-1:0] idx,
    output logic [W-1:0]   word
);

    logic [WORDS*W-1:0] padded;

    assign padded = {{(WORDS*W-N){1'b0}}, value};
    assign word   = padded[idx*W +: W];

endmodule

// File: rtl/pm_host_bridge.sv
// rtl/pm_host_bridge.sv - host-side driver that loads operands into the GF(2^233) point multiplier and streams back its result
// Ports: CLK/RST clock and async active-high reset; S_DATA/S_VALID/S_READY host operand stream;
//        M_DATA/M_VALID/M_READY result stream; PM_DIN_P_x/PM_DIN_P_y/PM_random_z/PM_key and PM_IN_VALID
//        drive the core; PM_DOUT_x/PM_DOUT_y/PM_OUT_VALID come back from it; BUSY while an operation is
//        in flight; ERR sticky watchdog timeout.
module pm_host_bridge
    import pm_host_pkg::*;
#(
    parameter int TIMEOUT = 1 << 20
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] S_DATA,
    input  logic         S_VALID,
    output logic         S_READY,
    output logic [W-1:0] M_DATA,
    output logic         M_VALID,
    input  logic         M_READY,
    output logic [N-1:0] PM_DIN_P_x,
    output logic [N-1:0] PM_DIN_P_y,
    output logic [N-1:0] PM_random_z,
    output logic [N-1:0] PM_key,
    output logic         PM_IN_VALID,
    input  logic [N-1:0] PM_DOUT_x,
    input  logic [N-1:0] PM_DOUT_y,
    input  logic         PM_OUT_VALID,
    output logic         BUSY,
    output logic         ERR
);

    localparam int TCW = $clog2(TIMEOUT) + 1;
    localparam logic [TCW-1:0]  TC_LAST = TCW'(TIMEOUT - 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(OPS * WORDS - 1);
    localparam logic [WCW-1:0]  K_LAST  = WCW'(WORDS - 1);

    state_t          state;
    logic [WC_W-1:0] wc;
    logic [3:0]      sc;
    logic [TCW-1:0]  tc;
    logic [N-1:0]    opnd [OPS];
    logic [N-1:0]    res_x;
    logic [N-1:0]    res_y;

    logic            s_accept;
    logic            m_accept;
    logic            out_qual;
    logic [1:0]      op_idx;
    logic [WCW-1:0]  word_idx;

    assign s_accept = S_VALID && S_READY;
    assign m_accept = M_VALID && M_READY;
    assign op_idx   = wc[WC_W-1 -: 2];
    assign word_idx = wc[WCW-1:0];
    // tc is 0 only in the first WAIT cycle, which blanks a valid left over from the last operation
    assign out_qual = PM_OUT_VALID && (tc != '0);

    assign PM_DIN_P_x  = opnd[OP_PX];
    assign PM_DIN_P_y  = opnd[OP_PY];
    assign PM_random_z = opnd[OP_Z];
    assign PM_key      = opnd[OP_KEY];

    // x words first, then y: sc[3] picks the coordinate, sc[2:0] the word
    pm_word_unpack u_unpack (
        .value (sc[3] ? res_y : res_x),
        .idx   (sc[2:0]),
        .word  (M_DATA)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            wc          <= '0;
            sc          <= '0;
            tc          <= '0;
            for (int i = 0; i < OPS; i++) opnd[i] <= '0;
            res_x       <= '0;
            res_y       <= '0;
            S_READY     <= 1'b0;
            M_VALID     <= 1'b0;
            PM_IN_VALID <= 1'b0;
            BUSY        <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state   <= ST_LOAD;
                    wc      <= '0;
                    S_READY <= 1'b1;
                end
                ST_LOAD: begin
                    if (s_accept) begin
                        for (int j = 0; j < WORDS - 1; j++) begin
                            if (int'(word_idx) == j) opnd[op_idx][j*W +: W] <= S_DATA;
                        end
                        // the top word only carries the remaining N-W*(WORDS-1) bits
                        if (word_idx == K_LAST) begin
                            opnd[op_idx][N-1:W*(WORDS-1)] <= S_DATA[N-W*(WORDS-1)-1:0];
                        end
                        wc <= wc + 1'b1;
                        if (wc == WC_LAST) begin
                            state       <= ST_FIRE;
                            S_READY     <= 1'b0;
                            PM_IN_VALID <= 1'b1;
                            BUSY        <= 1'b1;
                            ERR         <= 1'b0;
                        end
                    end
                end
                ST_FIRE: begin
                    PM_IN_VALID <= 1'b0;
                    tc          <= '0;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    tc <= tc + 1'b1;
                    // a result arriving on the last watchdog cycle still wins
                    if (out_qual) begin
                        res_x   <= PM_DOUT_x;
                        res_y   <= PM_DOUT_y;
                        sc      <= '0;
                        M_VALID <= 1'b1;
                        state   <= ST_SEND;
                    end else if (tc == TC_LAST) begin
                        ERR     <= 1'b1;
                        BUSY    <= 1'b0;
                        S_READY <= 1'b1;
                        wc      <= '0;
                        state   <= ST_LOAD;
                    end
                end
                ST_SEND: begin
                    if (m_accept) begin
                        sc <= sc + 1'b1;
                        if (sc == 4'd15) begin
                            M_VALID <= 1'b0;
                            BUSY    <= 1'b0;
                            S_READY <= 1'b1;
                            wc      <= '0;
                            state   <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    S_READY     <= 1'b0;
                    M_VALID     <= 1'b0;
                    PM_IN_VALID <= 1'b0;
                    BUSY        <= 1'b0;
                end
            endcase
        end
    end

endmodule
